// File: rtl/fft_radix2_iterative.sv
// In-place iterative radix-2 DIT FFT/IFFT of N = 2^LOG2N complex points.
// Samples stream in over a valid/ready handshake and are stored bit-reversed.
// One butterfly runs per clock. Bins then stream out in natural order.
module fft_radix2_iterative #(
  parameter int LOG2N  = 4,
  parameter int DATA_W = 16,
  parameter int TW_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inverse,
  input  logic              scale_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_real,
  input  logic [DATA_W-1:0] in_imag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_real,
  output logic [DATA_W-1:0] out_imag,
  output logic [LOG2N-1:0]  out_index,
  output logic              out_last,
  output logic              busy
);
  localparam int N    = 1 << LOG2N;
  localparam int HALF = N / 2;
  localparam int KW   = LOG2N - 1;          // butterfly counter / twiddle index width
  localparam int SW   = $clog2(LOG2N);      // stage counter width
  localparam int FRAC = TW_W - 2;           // twiddle fraction bits, +1.0 = 2^FRAC
  localparam int PW   = DATA_W + TW_W + 2;  // full complex-product width
  localparam int ONE  = 1 << FRAC;

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_UNLOAD} state_t;

  // round-half-away-from-zero of a real value
  function automatic int tw_round(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction

  // forward twiddle exp(-j*2*pi*t/N) in Q2.FRAC; the inverse conjugates at use
  function automatic logic signed [TW_W-1:0] tw_val(input int t, input bit want_im);
    real ang;
    ang = 2.0 * 3.14159265358979323846 * real'(t) / real'(N);
    if (want_im) return TW_W'(tw_round(-real'(ONE) * $sin(ang)));
    return TW_W'(tw_round(real'(ONE) * $cos(ang)));
  endfunction

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
    return r;
  endfunction

  logic signed [TW_W-1:0] tw_re [HALF];
  logic signed [TW_W-1:0] tw_im [HALF];
  for (genvar t = 0; t < HALF; t++) begin : g_tw
    assign tw_re[t] = tw_val(t, 1'b0);
    assign tw_im[t] = tw_val(t, 1'b1);
  end

  state_t                   state_q, state_d;
  logic [LOG2N-1:0]         in_cnt_q, in_cnt_d;
  logic [SW-1:0]            stage_q, stage_d;
  logic [KW-1:0]            k_q, k_d;
  logic                     inv_q, inv_d, scl_q, scl_d;
  logic                     out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [LOG2N-1:0]         out_idx_q, out_idx_d;
  logic [DATA_W-1:0]        out_re_q, out_re_d, out_im_q, out_im_d;
  logic signed [DATA_W-1:0] mem_re_q [N];
  logic signed [DATA_W-1:0] mem_im_q [N];

  logic in_fire, out_fire, compute_done, last_in;
  assign in_fire      = in_valid & in_ready;
  assign out_fire     = out_valid_q & out_ready;
  assign compute_done = (stage_q == SW'(LOG2N - 1)) && (k_q == KW'(HALF - 1));
  assign last_in      = (in_cnt_q == LOG2N'(N - 1));

  // state register
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignment so every flop samples pre-edge values.
    if (rst) state_q <= S_LOAD;
    else     state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      S_LOAD:    if (in_fire && last_in)      state_d = S_COMPUTE;
      S_COMPUTE: if (compute_done)            state_d = S_UNLOAD;
      S_UNLOAD:  if (out_fire && out_last_q)  state_d = S_LOAD;
      default:                                state_d = S_LOAD;
    endcase
  end

  // handshake / status outputs decoded from state
  always_comb begin
    in_ready = (state_q == S_LOAD);
    busy     = (state_q != S_LOAD);
  end

  // butterfly addressing: top keeps the low s bits of k and inserts a 0 at bit s
  logic [LOG2N-1:0] k_ext, low_mask, span, top_idx, bot_idx;
  logic [KW-1:0]    tw_idx;
  always_comb begin
    k_ext    = LOG2N'(k_q);
    low_mask = ~({LOG2N{1'b1}} << stage_q);
    span     = LOG2N'(1) << stage_q;
    top_idx  = ((k_ext & ~low_mask) << 1) | (k_ext & low_mask);
    bot_idx  = top_idx | span;
    tw_idx   = KW'((k_ext & low_mask) << (LOG2N'(LOG2N - 1) - LOG2N'(stage_q)));
  end

  // butterfly datapath: p = b*W (floor), top' = a+p, bot' = a-p at DATA_W+1 bits
  logic signed [DATA_W-1:0] a_re, a_im, b_re, b_im;
  logic signed [TW_W-1:0]   w_re, w_im;
  logic signed [DATA_W:0]   p_re, p_im, sum_re, sum_im, dif_re, dif_im;
  logic [DATA_W-1:0]        top_re, top_im, bot_re, bot_im;
  always_comb begin
    a_re   = mem_re_q[top_idx];
    a_im   = mem_im_q[top_idx];
    b_re   = mem_re_q[bot_idx];
    b_im   = mem_im_q[bot_idx];
    w_re   = tw_re[tw_idx];
    w_im   = inv_q ? -tw_im[tw_idx] : tw_im[tw_idx];
    p_re   = (DATA_W+1)'((PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(w_im)) >>> FRAC);
    p_im   = (DATA_W+1)'((PW'(b_re) * PW'(w_im) + PW'(b_im) * PW'(w_re)) >>> FRAC);
    sum_re = (DATA_W+1)'(a_re) + p_re;
    sum_im = (DATA_W+1)'(a_im) + p_im;
    dif_re = (DATA_W+1)'(a_re) - p_re;
    dif_im = (DATA_W+1)'(a_im) - p_im;
    if (scl_q) begin
      top_re = sum_re[DATA_W:1];
      top_im = sum_im[DATA_W:1];
      bot_re = dif_re[DATA_W:1];
      bot_im = dif_im[DATA_W:1];
    end else begin
      top_re = sum_re[DATA_W-1:0];
      top_im = sum_im[DATA_W-1:0];
      bot_re = dif_re[DATA_W-1:0];
      bot_im = dif_im[DATA_W-1:0];
    end
  end

  // sample memory: bit-reversed load, then in-place butterfly write-back
  always_ff @(posedge clk) begin
    // NOTE: the sample array is never reset; its contents are rewritten before use.
    if (state_q == S_LOAD && in_fire) begin
      mem_re_q[bitrev(in_cnt_q)] <= in_real;
      mem_im_q[bitrev(in_cnt_q)] <= in_imag;
    end else if (state_q == S_COMPUTE) begin
      mem_re_q[top_idx] <= top_re;
      mem_im_q[top_idx] <= top_im;
      mem_re_q[bot_idx] <= bot_re;
      mem_im_q[bot_idx] <= bot_im;
    end
  end

  // counters, frame mode latches and the registered output bin
  logic [LOG2N-1:0] nxt_idx;
  always_comb begin
    in_cnt_d    = in_cnt_q;
    stage_d     = stage_q;
    k_d         = k_q;
    inv_d       = inv_q;
    scl_d       = scl_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_idx_d   = out_idx_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    nxt_idx     = out_idx_q + 1'b1;
    unique case (state_q)
      S_LOAD: if (in_fire) begin
        in_cnt_d = in_cnt_q + 1'b1;
        if (in_cnt_q == '0) begin
          inv_d = inverse;
          scl_d = scale_en;
        end
      end
      S_COMPUTE: begin
        k_d = k_q + 1'b1;
        if (k_q == KW'(HALF - 1))
          stage_d = (stage_q == SW'(LOG2N - 1)) ? '0 : stage_q + 1'b1;
      end
      S_UNLOAD: if (!out_valid_q) begin
        out_valid_d = 1'b1;
        out_last_d  = 1'b0;
        out_idx_d   = '0;
        out_re_d    = mem_re_q[0];
        out_im_d    = mem_im_q[0];
      end else if (out_ready) begin
        if (out_last_q) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end else begin
          out_idx_d  = nxt_idx;
          out_re_d   = mem_re_q[nxt_idx];
          out_im_d   = mem_im_q[nxt_idx];
          out_last_d = (nxt_idx == LOG2N'(N - 1));
        end
      end
      default: ;
    endcase
  end

  // datapath register bank
  always_ff @(posedge clk) begin
    if (rst) begin
      in_cnt_q    <= '0;
      stage_q     <= '0;
      k_q         <= '0;
      inv_q       <= 1'b0;
      scl_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_idx_q   <= '0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      in_cnt_q    <= in_cnt_d;
      stage_q     <= stage_d;
      k_q         <= k_d;
      inv_q       <= inv_d;
      scl_q       <= scl_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_idx_q   <= out_idx_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_index = out_idx_q;
  assign out_real  = out_re_q;
  assign out_imag  = out_im_q;

endmodule

// File: tb/tb_fft_radix2_iterative.sv
// Directed bench: a 4-point instance for the reference vector, backpressure and
// reset cases, and a 16-point instance driven from a table of frames.
module tb_fft_radix2_iterative;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // 4-point instance
  logic        a_inv, a_scl, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_busy;
  logic [15:0] a_in_re, a_in_im, a_out_re, a_out_im;
  logic [1:0]  a_out_idx;

  // 16-point instance
  logic        b_inv, b_scl, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_busy;
  logic [15:0] b_in_re, b_in_im, b_out_re, b_out_im;
  logic [3:0]  b_out_idx;

  fft_radix2_iterative #(.LOG2N(2), .DATA_W(16), .TW_W(16)) u_fft4 (
    .clk(clk), .rst(rst), .inverse(a_inv), .scale_en(a_scl),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_real(a_in_re), .in_imag(a_in_im),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_real(a_out_re), .out_imag(a_out_im),
    .out_index(a_out_idx), .out_last(a_out_last), .busy(a_busy)
  );

  fft_radix2_iterative #(.LOG2N(4), .DATA_W(16), .TW_W(16)) u_fft16 (
    .clk(clk), .rst(rst), .inverse(b_inv), .scale_en(b_scl),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_real(b_in_re), .in_imag(b_in_im),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_real(b_out_re), .out_imag(b_out_im),
    .out_index(b_out_idx), .out_last(b_out_last), .busy(b_busy)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // 4-point reference: (1+5j, 2+6j, 3+7j, 4+8j) -> 10+26j, -4+0j, -2-2j, 0-4j
  int ref_in_re[4] = '{1, 2, 3, 4};
  int ref_in_im[4] = '{5, 6, 7, 8};
  int ref_ex_re[4] = '{10, -4, -2, 0};
  int ref_ex_im[4] = '{26, 0, -2, -4};

  // rounded 16384*cos / 16384*sin of 2*pi*k/16, k = 0..7
  int cos_t[8] = '{16384, 15137, 11585, 6270, 0, -6270, -11585, -15137};
  int sin_t[8] = '{0, 6270, 11585, 15137, 16384, 15137, 11585, 6270};

  typedef struct {
    string name;
    bit    inv;
    bit    scl;
    int    in_re[16];
    int    in_im[16];
    int    ex_re[16];
    int    ex_im[16];
  } vec_t;
  vec_t vecs[6];

  // 4-point: stream the reference frame; optionally keep in_valid high with junk after it
  task automatic send4(input bit hold);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_in_valid = 1'b1;
      a_in_re    = 16'(ref_in_re[i]);
      a_in_im    = 16'(ref_in_im[i]);
      a_inv      = 1'b0;
      a_scl      = 1'b0;
      check($sformatf("n4 in_ready load %0d", i), a_in_ready, 1);
    end
    @(negedge clk);
    if (hold) begin
      a_in_re = 16'h7777;
      a_in_im = 16'h7777;
    end else begin
      a_in_valid = 1'b0;
    end
    check("n4 in_ready after last accept", a_in_ready, 0);
    check("n4 busy after last accept", a_busy, 1);
  endtask

  // 4-point: wait for the first bin, then unload under an out_ready pattern
  task automatic recv4(input logic [31:0] pat);
    int lat = 0;
    int idx = 0;
    int cyc = 0;
    while (!a_out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("n4 latency", lat, 5);
    a_in_valid = 1'b0;
    while (idx < 4 && cyc < 64) begin
      a_out_ready = pat[cyc % 32];
      check($sformatf("n4 c%0d valid", cyc), a_out_valid, 1);
      check($sformatf("n4 c%0d index", cyc), a_out_idx, idx);
      check($sformatf("n4 c%0d re", cyc), $signed(a_out_re), ref_ex_re[idx]);
      check($sformatf("n4 c%0d im", cyc), $signed(a_out_im), ref_ex_im[idx]);
      check($sformatf("n4 c%0d last", cyc), a_out_last, (idx == 3) ? 1 : 0);
      check($sformatf("n4 c%0d in_ready", cyc), a_in_ready, 0);
      if (a_out_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    check("n4 bins accepted", idx, 4);
    check("n4 out_valid after last", a_out_valid, 0);
    check("n4 busy after last", a_busy, 0);
    check("n4 in_ready after last", a_in_ready, 1);
    a_out_ready = 1'b0;
  endtask

  // 16-point: one full frame from the table, mode inputs flipped after sample 0
  task automatic run16(input vec_t v);
    int lat = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      b_in_valid = 1'b1;
      b_in_re    = 16'(v.in_re[i]);
      b_in_im    = 16'(v.in_im[i]);
      b_inv      = (i == 0) ? v.inv : ~v.inv;
      b_scl      = (i == 0) ? v.scl : ~v.scl;
      check($sformatf("%s in_ready %0d", v.name, i), b_in_ready, 1);
    end
    @(negedge clk);
    b_in_valid = 1'b0;
    check($sformatf("%s in_ready drop", v.name), b_in_ready, 0);
    while (!b_out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("%s latency", v.name), lat, 33);
    b_out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("%s bin%0d valid", v.name, k), b_out_valid, 1);
      check($sformatf("%s bin%0d index", v.name, k), b_out_idx, k);
      check($sformatf("%s bin%0d re", v.name, k), $signed(b_out_re), v.ex_re[k]);
      check($sformatf("%s bin%0d im", v.name, k), $signed(b_out_im), v.ex_im[k]);
      check($sformatf("%s bin%0d last", v.name, k), b_out_last, (k == 15) ? 1 : 0);
    end
    @(negedge clk);
    b_out_ready = 1'b0;
    check($sformatf("%s out_valid after", v.name), b_out_valid, 0);
    check($sformatf("%s busy after", v.name), b_busy, 0);
    check($sformatf("%s in_ready after", v.name), b_in_ready, 1);
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    a_inv = 1'b0; a_scl = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    a_in_re = '0; a_in_im = '0;
    b_inv = 1'b0; b_scl = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    b_in_re = '0; b_in_im = '0;

    for (int v = 0; v < 6; v++) begin
      vecs[v].inv = 1'b0;
      vecs[v].scl = 1'b0;
      for (int i = 0; i < 16; i++) begin
        vecs[v].in_re[i] = 0; vecs[v].in_im[i] = 0;
        vecs[v].ex_re[i] = 0; vecs[v].ex_im[i] = 0;
      end
    end
    vecs[0].name = "impulse";
    vecs[0].in_re[0] = 1000;
    for (int i = 0; i < 16; i++) vecs[0].ex_re[i] = 1000;
    vecs[1].name = "dc";
    for (int i = 0; i < 16; i++) vecs[1].in_re[i] = 100;
    vecs[1].ex_re[0] = 1600;
    vecs[2].name = "dc_scaled";
    vecs[2].scl = 1'b1;
    for (int i = 0; i < 16; i++) vecs[2].in_re[i] = 100;
    vecs[2].ex_re[0] = 100;
    vecs[3].name = "ifft_scaled";
    vecs[3].inv = 1'b1;
    vecs[3].scl = 1'b1;
    vecs[3].in_re[0] = 16;
    for (int i = 0; i < 16; i++) vecs[3].ex_re[i] = 1;
    vecs[4].name = "tw_fwd";
    vecs[4].in_re[1] = 16384;
    vecs[5].name = "tw_inv";
    vecs[5].inv = 1'b1;
    vecs[5].in_re[1] = 16384;
    for (int k = 0; k < 8; k++) begin
      vecs[4].ex_re[k] = cos_t[k];  vecs[4].ex_im[k] = -sin_t[k];
      vecs[4].ex_re[k+8] = -cos_t[k]; vecs[4].ex_im[k+8] = sin_t[k];
      vecs[5].ex_re[k] = cos_t[k];  vecs[5].ex_im[k] = sin_t[k];
      vecs[5].ex_re[k+8] = -cos_t[k]; vecs[5].ex_im[k+8] = -sin_t[k];
    end

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst in_ready", a_in_ready, 1);
    check("rst out_valid", a_out_valid, 0);
    check("rst out_last", a_out_last, 0);
    check("rst busy", a_busy, 0);
    check("rst out_real", a_out_re, 0);
    check("rst out_imag", a_out_im, 0);
    check("rst out_index", a_out_idx, 0);
    check("rst n16 in_ready", b_in_ready, 1);
    check("rst n16 busy", b_busy, 0);

    // reference vector with in_valid held through COMPUTE and stalled unload
    send4(1'b1);
    recv4(32'hA5C3_9264);

    // table of 16-point frames
    for (int v = 0; v < 6; v++) run16(vecs[v]);

    // reset midway through COMPUTE
    send4(1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst compute out_valid", a_out_valid, 0);
    check("rst compute busy", a_busy, 0);
    check("rst compute in_ready", a_in_ready, 1);

    // reset during UNLOAD with out_ready low
    send4(1'b0);
    guard = 0;
    while (!a_out_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("unload reached", a_out_valid, 1);
    repeat (2) @(negedge clk);
    check("unload stalled index", a_out_idx, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst unload out_valid", a_out_valid, 0);
    check("rst unload busy", a_busy, 0);
    check("rst unload in_ready", a_in_ready, 1);
    check("rst unload out_last", a_out_last, 0);

    // fresh frame after the resets
    send4(1'b0);
    recv4(32'hFFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
